// File: rtl/key_event_pkg.sv
// Shared definitions for the key event detector.
//   state_t      : detector FSM states (LOCKOUT, IDLE, PRESSED, HELD)
//   TICK_W       : width of the hold / repeat tick counters
//   KEY_PRESSED  : debounced key level while pressed (active low)
//   KEY_RELEASED : debounced key level while released
package key_event_pkg;

  localparam int unsigned TICK_W = 16;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  typedef enum logic [1:0] {
    LOCKOUT = 2'd0,
    IDLE    = 2'd1,
    PRESSED = 2'd2,
    HELD    = 2'd3
  } state_t;

endpackage

// File: rtl/key_event_detector_tick_prescaler.sv
// tick_prescaler: divides clk into timing ticks.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : synchronous clear, holds the count at 0
//   en   : count enable
//   tick : one-cycle pulse while enabled and the count sits at PRESCALE-1;
//          the count wraps to 0 on that same edge
module tick_prescaler #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_event_detector.sv
// key_event_detector: turns a debounced active-low key level into one-cycle
// UI event pulses. All outputs are registered (1 clk after the deciding edge).
//   clk           : system clock
//   rst           : synchronous active-high reset
//   keyDeBounce   : debounced key level, 0 = pressed, 1 = released
//   key_down      : 1 while the key is considered pressed
//   press_pulse   : accepted press
//   release_pulse : accepted release
//   short_pulse   : release before the long threshold
//   long_pulse    : hold reached LONG_TICKS (once per press)
//   repeat_pulse  : auto-repeat every REPEAT_TICKS ticks after long press
// Optional feature macro: KEY_REPEAT_EN (auto-repeat); without it
// repeat_pulse is constant 0.
module key_event_detector
  import key_event_pkg::*;
#(
  parameter int unsigned        PRESCALE     = 50000,
  parameter logic [TICK_W-1:0]  LONG_TICKS   = 16'd800,
  parameter logic [TICK_W-1:0]  REPEAT_TICKS = 16'd100
) (
  input  logic clk,
  input  logic rst,
  input  logic keyDeBounce,
  output logic key_down,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  state_t state, state_next;
  logic   key_prev;
  logic   tick;
  logic   counting;
  logic   key_down_next, press_next, release_next, short_next, long_next;
  logic [TICK_W-1:0] hold, hold_next, hold_inc;

  assign counting = (state == PRESSED) || (state == HELD);
  assign hold_inc = hold + TICK_W'(1);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (!counting),
    .en  (counting),
    .tick(tick)
  );

`ifdef KEY_REPEAT_EN
  logic [TICK_W-1:0] rep, rep_next, rep_inc;
  logic              repeat_next;
  assign rep_inc = rep + TICK_W'(1);
`endif

  always_comb begin
    state_next    = state;
    key_down_next = key_down;
    press_next    = 1'b0;
    release_next  = 1'b0;
    short_next    = 1'b0;
    long_next     = 1'b0;
    hold_next     = hold;
`ifdef KEY_REPEAT_EN
    rep_next      = rep;
    repeat_next   = 1'b0;
`endif
    unique case (state)
      LOCKOUT: begin
        key_down_next = 1'b0;
        if (keyDeBounce == KEY_RELEASED) state_next = IDLE;
      end
      IDLE: begin
        if (keyDeBounce == KEY_PRESSED && key_prev == KEY_RELEASED) begin
          state_next    = PRESSED;
          press_next    = 1'b1;
          key_down_next = 1'b1;
          hold_next     = '0;
        end
      end
      PRESSED: begin
        // Release is checked before the tick so a release on the threshold
        // edge is reported as short, never long.
        if (keyDeBounce == KEY_RELEASED) begin
          state_next    = IDLE;
          release_next  = 1'b1;
          short_next    = 1'b1;
          key_down_next = 1'b0;
        end else if (tick) begin
          hold_next = hold_inc;
          if (hold_inc == LONG_TICKS) begin
            state_next = HELD;
            long_next  = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_next   = '0;
`endif
          end
        end
      end
      HELD: begin
        if (keyDeBounce == KEY_RELEASED) begin
          state_next    = IDLE;
          release_next  = 1'b1;
          key_down_next = 1'b0;
        end else if (tick) begin
          if (hold != '1) hold_next = hold_inc;
`ifdef KEY_REPEAT_EN
          if (rep_inc == REPEAT_TICKS) begin
            rep_next    = '0;
            repeat_next = 1'b1;
          end else begin
            rep_next    = rep_inc;
          end
`endif
        end
      end
      default: state_next = LOCKOUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOCKOUT;
      key_prev      <= KEY_RELEASED;
      key_down      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      hold          <= '0;
    end else begin
      state         <= state_next;
      key_prev      <= keyDeBounce;
      key_down      <= key_down_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      short_pulse   <= short_next;
      long_pulse    <= long_next;
      hold          <= hold_next;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rep          <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rep          <= rep_next;
      repeat_pulse <= repeat_next;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_detector.sv
module tb_key_event_detector;
  import key_event_pkg::*;

  localparam logic [4:0] M_PRESS = 5'b10000;
  localparam logic [4:0] M_REL   = 5'b01000;
  localparam logic [4:0] M_SHORT = 5'b01100;
  localparam logic [4:0] M_LONG  = 5'b00010;
  localparam logic [4:0] M_REP   = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic keyDeBounce = 1'b0;
  logic key_down, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  ev_t  sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_event_detector #(
    .PRESCALE    (4),
    .LONG_TICKS  (16'd10),
    .REPEAT_TICKS(16'd3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .keyDeBounce  (keyDeBounce),
    .key_down     (key_down),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int at, input logic [4:0] mask);
    ev_t e;
    e.cyc  = at;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic check_kd(input string tag, input logic exp);
    n_checks++;
    assert (key_down === exp) else begin
      n_fail++;
      $error("FAIL %s: key_down observed %b expected %b", tag, key_down, exp);
    end
  endtask

  // Drive a press now; returns the edge that samples it.
  task automatic do_press(output int e0);
    keyDeBounce = 1'b0;
    e0 = cyc + 1;
    push(e0, M_PRESS);
    wait_cycles(1);
    check_kd("key_down_after_press", 1'b1);
  endtask

  // Release so that it is sampled on edge 'at'.
  task automatic do_release(input int at, input logic [4:0] mask);
    if (at - 1 > cyc) wait_cycles(at - 1 - cyc);
    keyDeBounce = 1'b1;
    push(at, mask);
    wait_cycles(1);
    check_kd("key_down_after_release", 1'b0);
  endtask

  initial begin
    int e0;
    logic [4:0] exp;
    logic [4:0] got;

    // Scoreboard monitor: every cycle, pulses must match the queued event
    // for this cycle, or be all zero.
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          exp = 5'b0;
          if (sb.size() > 0 && sb[0].cyc == cyc) exp = sb.pop_front().mask;
          got = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse};
          n_checks++;
          assert (got === exp) else begin
            n_fail++;
            $error("FAIL pulses cyc=%0d: observed %b expected %b", cyc, got, exp);
          end
        end
      end
    join_none

    // Reset with key held, then 100 cycles still held: LOCKOUT, no pulses.
    rst = 1'b1;
    keyDeBounce = 1'b0;
    wait_cycles(2);
    chk_en = 1'b1;
    check_kd("reset_key_down", 1'b0);
    n_checks++;
    assert (dut.state === LOCKOUT) else begin
      n_fail++;
      $error("FAIL reset_state: observed %0d expected %0d", dut.state, LOCKOUT);
    end
    rst = 1'b0;
    wait_cycles(100);
    check_kd("lockout_key_down", 1'b0);
    keyDeBounce = 1'b1;
    wait_cycles(5);

    // Short press: 20 clk held.
    do_press(e0);
    do_release(e0 + 20, M_SHORT);
    wait_cycles(5);

    // Long press: 60 clk held, long at +40, release without short.
    do_press(e0);
    push(e0 + 40, M_LONG);
`ifdef KEY_REPEAT_EN
    push(e0 + 52, M_REP);
`endif
    do_release(e0 + 60, M_REL);
    wait_cycles(5);

    // Release on the exact threshold edge: short wins, no long.
    do_press(e0);
    do_release(e0 + 40, M_SHORT);
    wait_cycles(5);

    // 100+ clk hold: repeats every 12 clk after long (when enabled).
    do_press(e0);
    push(e0 + 40, M_LONG);
`ifdef KEY_REPEAT_EN
    for (int k = 52; k <= 100; k += 12) push(e0 + k, M_REP);
`endif
    do_release(e0 + 104, M_REL);
    wait_cycles(5);

    // Reset mid-hold at tick 7: everything clears, no events while held.
    do_press(e0);
    if (e0 + 27 > cyc) wait_cycles(e0 + 27 - cyc);
    rst = 1'b1;
    wait_cycles(1);
    check_kd("midhold_reset_key_down", 1'b0);
    n_checks++;
    assert (dut.state === LOCKOUT) else begin
      n_fail++;
      $error("FAIL midhold_reset_state: observed %0d expected %0d", dut.state, LOCKOUT);
    end
    rst = 1'b0;
    wait_cycles(30);
    check_kd("held_after_reset_key_down", 1'b0);
    keyDeBounce = 1'b1;
    wait_cycles(3);
    do_press(e0);
    do_release(e0 + 8, M_SHORT);
    wait_cycles(5);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
